timer_input_capture: RTL and testbench

// - Input-capture channel for the microcontroller timer block; the input-side complement of the

---
 rtl/timer_input_capture_pkg.sv | 44 ++++
 rtl/timer_input_capture_input_filter.sv | 85 ++++++++
 rtl/timer_input_capture.sv | 138 +++++++++++++
 tb/tb_timer_input_capture.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_input_capture_pkg.sv
// Shared definitions for the timer input-capture channel: register map,
// CTRL/STATUS bit positions, edge-select and filter-state encodings.
package timer_input_capture_pkg;

    typedef enum logic [1:0] {
        ADDR_CTRL    = 2'd0,
        ADDR_STATUS  = 2'd1,
        ADDR_CAPTURE = 2'd2,
        ADDR_RSVD    = 2'd3
    } reg_addr_e;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_sel_e;

    typedef enum logic {
        FILT_STABLE   = 1'b0,
        FILT_COUNTING = 1'b1
    } filt_state_e;

    localparam int unsigned CTRL_EN_BIT      = 0;
    localparam int unsigned CTRL_EDGE_LSB    = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT  = 3;
    localparam int unsigned CTRL_FILT_LSB    = 4;

    localparam int unsigned STATUS_VALID_BIT = 0;
    localparam int unsigned STATUS_OVR_BIT   = 1;

    function automatic logic edge_match(input edge_sel_e sel, input logic rise, input logic fall);
        logic hit;
        hit = 1'b0;
        case (sel)
            EDGE_RISE: hit = rise;
            EDGE_FALL: hit = fall;
            EDGE_BOTH: hit = rise | fall;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/timer_input_capture_input_filter.sv
// Two-flop synchroniser plus deglitch filter: the output level flips only after
// filt_len+1 consecutive synchronised samples disagree with it.
module input_filter
    import timer_input_capture_pkg::*;
#(
    parameter int unsigned FILT_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pin,
    input  logic [FILT_BITS-1:0] filt_len,
    output logic                 level
);

    logic                 sync1;
    logic                 sync2;
    filt_state_e          state;
    filt_state_e          state_nxt;
    logic [FILT_BITS-1:0] cnt;
    logic [FILT_BITS-1:0] cnt_nxt;
    logic                 level_q;
    logic                 level_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FILT_STABLE;
            cnt     <= '0;
            level_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            level_q <= level_nxt;
        end
    end

    // cnt holds mismatches seen so far; >= keeps a shortened filt_len effective mid-count
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = level_q;
        case (state)
            FILT_STABLE: begin
                if (sync2 != level_q) begin
                    if (filt_len == '0) begin
                        level_nxt = sync2;
                    end else begin
                        state_nxt = FILT_COUNTING;
                        cnt_nxt   = FILT_BITS'(1);
                    end
                end
            end
            FILT_COUNTING: begin
                if (sync2 == level_q) begin
                    state_nxt = FILT_STABLE;
                    cnt_nxt   = '0;
                end else if (cnt >= filt_len) begin
                    state_nxt = FILT_STABLE;
                    cnt_nxt   = '0;
                    level_nxt = sync2;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = FILT_STABLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        level = level_q;
    end

endmodule

// File: rtl/timer_input_capture.sv
// Timer input-capture channel: filtered edge detection, capture/status registers,
// peripheral bus decode and level interrupt.
module timer_input_capture
    import timer_input_capture_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned FILT_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cap_in,
    input  logic [CNT_WIDTH-1:0] counter_value,
    input  logic [1:0]           bus_addr,
    input  logic                 bus_wr,
    input  logic                 bus_rd,
    input  logic [31:0]          bus_wdata,
    output logic [31:0]          bus_rdata,
    output logic                 irq
);

    localparam int unsigned CTRL_W = CTRL_FILT_LSB + FILT_BITS;

    logic [CTRL_W-1:0]    ctrl;
    logic [CNT_WIDTH-1:0] capture;
    logic                 valid;
    logic                 overrun;
    logic                 valid_nxt;
    logic                 overrun_nxt;
    logic                 filtered;
    logic                 filtered_d;

    logic                 ctrl_en;
    logic                 ctrl_irq_en;
    edge_sel_e            ctrl_edge;
    logic [FILT_BITS-1:0] filt_len;

    reg_addr_e            addr;
    logic                 ctrl_wr;
    logic                 status_wr;
    logic                 capture_rd;
    logic                 rise;
    logic                 fall;
    logic                 cap_event;
    logic [31:0]          rdata_mux;
    logic                 unused_wdata;

    always_comb begin
        ctrl_en     = ctrl[CTRL_EN_BIT];
        ctrl_irq_en = ctrl[CTRL_IRQ_EN_BIT];
        ctrl_edge   = edge_sel_e'(ctrl[CTRL_EDGE_LSB +: 2]);
        filt_len    = ctrl[CTRL_FILT_LSB +: FILT_BITS];
    end

    input_filter #(
        .FILT_BITS (FILT_BITS)
    ) u_filter (
        .clk      (clk),
        .reset    (reset),
        .pin      (cap_in),
        .filt_len (filt_len),
        .level    (filtered)
    );

    always_comb begin
        addr         = reg_addr_e'(bus_addr);
        ctrl_wr      = bus_wr && (addr == ADDR_CTRL);
        status_wr    = bus_wr && (addr == ADDR_STATUS);
        capture_rd   = bus_rd && (addr == ADDR_CAPTURE);
        unused_wdata = ^bus_wdata[31:CTRL_W];
    end

    // The filter keeps running while disabled, so filtered_d never holds a stale level.
    always_comb begin
        rise      = filtered & ~filtered_d;
        fall      = ~filtered & filtered_d;
        cap_event = ctrl_en & edge_match(ctrl_edge, rise, fall);
    end

    // Set beats clear; a capture read in the event cycle consumes the old value, so no overrun.
    always_comb begin
        valid_nxt   = valid;
        overrun_nxt = overrun;
        if (capture_rd || (status_wr && bus_wdata[STATUS_VALID_BIT])) begin
            valid_nxt = 1'b0;
        end
        if (status_wr && bus_wdata[STATUS_OVR_BIT]) begin
            overrun_nxt = 1'b0;
        end
        if (cap_event) begin
            valid_nxt = 1'b1;
            if (valid && !capture_rd) begin
                overrun_nxt = 1'b1;
            end
        end
    end

    always_comb begin
        rdata_mux = '0;
        case (addr)
            ADDR_CTRL:    rdata_mux[CTRL_W-1:0] = ctrl;
            ADDR_STATUS: begin
                rdata_mux[STATUS_VALID_BIT] = valid;
                rdata_mux[STATUS_OVR_BIT]   = overrun;
            end
            ADDR_CAPTURE: rdata_mux[CNT_WIDTH-1:0] = capture;
            default:      rdata_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl       <= '0;
            capture    <= '0;
            valid      <= 1'b0;
            overrun    <= 1'b0;
            filtered_d <= 1'b0;
            bus_rdata  <= '0;
        end else begin
            filtered_d <= filtered;
            valid      <= valid_nxt;
            overrun    <= overrun_nxt;
            if (ctrl_wr) begin
                ctrl <= bus_wdata[CTRL_W-1:0];
            end
            if (cap_event) begin
                capture <= counter_value;
            end
            if (bus_rd) begin
                bus_rdata <= rdata_mux;
            end
        end
    end

    always_comb begin
        irq = ctrl_irq_en & (valid | overrun);
    end

endmodule

// File: tb/tb_timer_input_capture.sv
// Self-checking bench for timer_input_capture: vector table, corner-case sequences
// and a randomized run against a window-based reference model.
module tb_timer_input_capture;

    localparam int HIST = 16384;

    logic        clk = 1'b0;
    logic        reset;
    logic        cap_in;
    logic [15:0] counter_value;
    logic [1:0]  bus_addr;
    logic        bus_wr;
    logic        bus_rd;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        irq;

    always #5 clk = ~clk;

    timer_input_capture #(
        .CNT_WIDTH (16),
        .FILT_BITS (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cap_in        (cap_in),
        .counter_value (counter_value),
        .bus_addr      (bus_addr),
        .bus_wr        (bus_wr),
        .bus_rd        (bus_rd),
        .bus_wdata     (bus_wdata),
        .bus_rdata     (bus_rdata),
        .irq           (irq)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model state: pin value seen at every clock edge, plus register image.
    logic        pin_hist [0:HIST-1];
    logic [7:0]  m_ctrl;
    logic [15:0] m_cap;
    logic        m_valid;
    logic        m_ovr;
    logic        m_level;
    logic        m_flipped;
    logic [31:0] m_rdata;

    typedef struct {
        logic [31:0] ctrl;
        int          len;
        logic [1:0]  exp_status;
        logic        exp_irq;
        int          cap_edge;
    } vec_t;

    vec_t vecs [14];

    function automatic logic [15:0] val(input int c);
        return 16'(c * 37 + 100);
    endfunction

    // Synchronised sample seen by the filter at edge x is the pin taken two edges earlier.
    function automatic logic filt_sample(input int x);
        int i;
        i = x - 2;
        if (i < 1) return 1'b0;
        return pin_hist[i];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_edge();
        int   e;
        int   f;
        logic ev;
        logic cap_rd;
        logic st_wr;
        logic mism;
        logic old_valid;
        e = cyc + 1;
        if (e >= HIST) begin
            n_errors++;
            $display("FAIL history_bound: cycle %0d, limit %0d", e, HIST);
            $fatal(1, "history exhausted");
        end
        if (reset) begin
            pin_hist[e] = 1'b0;
            m_ctrl    = '0;
            m_cap     = '0;
            m_valid   = 1'b0;
            m_ovr     = 1'b0;
            m_level   = 1'b0;
            m_flipped = 1'b0;
            m_rdata   = '0;
            return;
        end
        pin_hist[e] = cap_in;
        ev     = m_ctrl[0] && m_flipped && ((m_level && m_ctrl[1]) || (!m_level && m_ctrl[2]));
        cap_rd = bus_rd && (bus_addr == 2'd2);
        st_wr  = bus_wr && (bus_addr == 2'd1);
        if (bus_rd) begin
            case (bus_addr)
                2'd0:    m_rdata = {24'd0, m_ctrl};
                2'd1:    m_rdata = {30'd0, m_ovr, m_valid};
                2'd2:    m_rdata = {16'd0, m_cap};
                default: m_rdata = 32'd0;
            endcase
        end
        f    = int'(m_ctrl[7:4]);
        mism = 1'b1;
        for (int j = 0; j <= f; j++) begin
            if (filt_sample(e - j) == m_level) mism = 1'b0;
        end
        old_valid = m_valid;
        if (cap_rd || (st_wr && bus_wdata[0])) m_valid = 1'b0;
        if (st_wr && bus_wdata[1]) m_ovr = 1'b0;
        if (ev) begin
            m_cap   = counter_value;
            m_valid = 1'b1;
            if (old_valid && !cap_rd) m_ovr = 1'b1;
        end
        if (bus_wr && (bus_addr == 2'd0)) m_ctrl = bus_wdata[7:0];
        if (mism) m_level = !m_level;
        m_flipped = mism;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        cyc++;
        #2;
        counter_value = val(cyc);
        check("model_rdata", bus_rdata, m_rdata);
        check("model_irq", 32'(irq), 32'(m_ctrl[3] && (m_valid || m_ovr)));
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus_addr  = a;
        bus_wdata = d;
        bus_wr    = 1'b1;
        step();
        bus_wr    = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus_addr = a;
        bus_rd   = 1'b1;
        step();
        bus_rd   = 1'b0;
        d        = bus_rdata;
    endtask

    task automatic pulse(input int len, output int k);
        k      = cyc + 1;
        cap_in = 1'b1;
        repeat (len) step();
        cap_in = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] w;
        logic [15:0] old_cap;
        int          k;
        int          k2;
        int          hold;
        int          r;

        reset = 1'b1; cap_in = 1'b0; bus_addr = 2'd0; bus_wr = 1'b0; bus_rd = 1'b0;
        bus_wdata = '0; counter_value = val(0); pin_hist[0] = 1'b0;
        m_ctrl = '0; m_cap = '0; m_valid = 1'b0; m_ovr = 1'b0;
        m_level = 1'b0; m_flipped = 1'b0; m_rdata = '0;
        repeat (3) step();
        reset = 1'b0;

        // Reset state
        check("reset_irq", 32'(irq), 32'd0);
        check("reset_rdata", bus_rdata, 32'd0);
        bus_read(2'd0, d); check("reset_ctrl", d, 32'd0);
        bus_read(2'd1, d); check("reset_status", d, 32'd0);
        bus_read(2'd2, d); check("reset_capture", d, 32'd0);

        // CTRL keeps only its defined bits; reserved address reads zero
        bus_write(2'd0, 32'hFFFF_FF3B);
        bus_read(2'd0, d); check("ctrl_mask", d, 32'h0000_003B);
        bus_read(2'd3, d); check("reserved_read", d, 32'd0);

        // {ctrl, pulse length, STATUS, irq, capture edge offset from first pin sample}
        vecs[0]  = '{32'h03, 4,  2'b01, 1'b0, 3};
        vecs[1]  = '{32'h3B, 2,  2'b00, 1'b0, 0};
        vecs[2]  = '{32'h3B, 6,  2'b01, 1'b1, 6};
        vecs[3]  = '{32'h3B, 3,  2'b00, 1'b0, 0};
        vecs[4]  = '{32'h3B, 4,  2'b01, 1'b1, 6};
        vecs[5]  = '{32'h05, 4,  2'b01, 1'b0, 7};
        vecs[6]  = '{32'h07, 4,  2'b11, 1'b0, 7};
        vecs[7]  = '{32'h02, 4,  2'b00, 1'b0, 0};
        vecs[8]  = '{32'h0D, 1,  2'b01, 1'b1, 4};
        vecs[9]  = '{32'h1B, 1,  2'b00, 1'b0, 0};
        vecs[10] = '{32'h1B, 2,  2'b01, 1'b1, 4};
        vecs[11] = '{32'hFB, 15, 2'b00, 1'b0, 0};
        vecs[12] = '{32'hFB, 16, 2'b01, 1'b1, 18};
        vecs[13] = '{32'h09, 4,  2'b00, 1'b0, 0};

        foreach (vecs[i]) begin
            bus_write(2'd0, vecs[i].ctrl);
            bus_write(2'd1, 32'h3);
            repeat (2) step();
            pulse(vecs[i].len, k);
            repeat (30) step();
            check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
            bus_read(2'd1, d);
            check($sformatf("vec%0d_status", i), d, 32'(vecs[i].exp_status));
            if (vecs[i].cap_edge != 0) begin
                bus_read(2'd2, d);
                check($sformatf("vec%0d_capture", i), d, 32'(val(k + vecs[i].cap_edge - 1)));
            end
        end

        // Both edges without a read: newest timestamp, overrun; then W1C behaviour
        bus_write(2'd0, 32'h07);
        bus_write(2'd1, 32'h3);
        pulse(4, k);
        repeat (20) step();
        bus_read(2'd1, d); check("both_status", d, 32'h3);
        bus_read(2'd2, d); check("both_capture", d, 32'(val(k + 6)));
        bus_write(2'd1, 32'h2);
        bus_read(2'd1, d); check("w1c_overrun", d, 32'h0);
        pulse(4, k);
        repeat (20) step();
        bus_write(2'd1, 32'h2);
        bus_read(2'd1, d); check("w1c_ovr_keeps_valid", d, 32'h1);
        bus_write(2'd1, 32'h0);
        bus_read(2'd1, d); check("w0_no_effect", d, 32'h1);
        bus_write(2'd1, 32'h1);
        bus_read(2'd1, d); check("w1c_valid", d, 32'h0);

        // Capture event in the same cycle as a CAPTURE read
        bus_write(2'd0, 32'h03);
        pulse(4, k);
        repeat (10) step();
        old_cap = val(k + 2);
        k2 = cyc + 1;
        cap_in = 1'b1;
        repeat (3) step();
        bus_addr = 2'd2; bus_rd = 1'b1;
        step();
        bus_rd = 1'b0;
        check("race_read_old", bus_rdata, 32'(old_cap));
        cap_in = 1'b0;
        repeat (10) step();
        bus_read(2'd1, d); check("race_read_status", d, 32'h1);
        bus_read(2'd2, d); check("race_read_capture", d, 32'(val(k2 + 2)));
        bus_read(2'd1, d); check("read_clears_valid", d, 32'h0);

        // Capture event in the same cycle as a STATUS write-1 of valid
        cap_in = 1'b1;
        repeat (3) step();
        bus_addr = 2'd1; bus_wdata = 32'h1; bus_wr = 1'b1;
        step();
        bus_wr = 1'b0;
        cap_in = 1'b0;
        repeat (10) step();
        bus_read(2'd1, d); check("race_w1c_status", d, 32'h1);

        // Falling-only select ignores the rising edge
        bus_write(2'd0, 32'h05);
        bus_write(2'd1, 32'h3);
        cap_in = 1'b1;
        repeat (20) step();
        bus_read(2'd1, d); check("fall_ignores_rise", d, 32'h0);
        cap_in = 1'b0;
        repeat (10) step();
        bus_read(2'd1, d); check("fall_captures", d, 32'h1);

        // Disabled channel with pin toggling, then re-enable with pin steady
        bus_write(2'd0, 32'h06);
        bus_write(2'd1, 32'h3);
        for (int t = 0; t < 8; t++) begin
            cap_in = ~cap_in;
            repeat (5) step();
        end
        bus_read(2'd1, d); check("disabled_status", d, 32'h0);
        cap_in = 1'b1;
        repeat (10) step();
        bus_write(2'd0, 32'h07);
        repeat (10) step();
        bus_read(2'd1, d); check("reenable_no_stale", d, 32'h0);
        cap_in = 1'b0;
        repeat (10) step();
        bus_read(2'd1, d); check("reenable_edge", d, 32'h1);

        // Reset while the filter is counting and valid=1
        bus_write(2'd0, 32'h3B);
        bus_write(2'd1, 32'h3);
        pulse(6, k);
        repeat (30) step();
        check("pre_reset_irq", 32'(irq), 32'd1);
        bus_read(2'd0, d); check("pre_reset_rdata", d, 32'h3B);
        cap_in = 1'b1;
        repeat (3) step();
        #1 reset = 1'b1;
        #1;
        check("async_reset_irq", 32'(irq), 32'd0);
        check("async_reset_rdata", bus_rdata, 32'd0);
        cap_in = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        bus_read(2'd0, d); check("post_reset_ctrl", d, 32'h0);
        bus_read(2'd1, d); check("post_reset_status", d, 32'h0);
        bus_read(2'd2, d); check("post_reset_capture", d, 32'h0);
        bus_write(2'd0, 32'h03);
        repeat (10) step();
        bus_read(2'd1, d); check("post_reset_no_capture", d, 32'h0);
        pulse(4, k);
        repeat (10) step();
        bus_read(2'd1, d); check("post_reset_new_edge", d, 32'h1);
        bus_read(2'd2, d); check("post_reset_capture_val", d, 32'(val(k + 2)));

        // Randomized traffic, checked every cycle against the reference model
        bus_write(2'd0, 32'h0F);
        hold = 0;
        for (int i = 0; i < 2000; i++) begin
            if (hold == 0) begin
                cap_in = 1'($urandom_range(0, 1));
                hold   = int'($urandom_range(1, 7));
            end
            hold--;
            bus_rd = 1'b0;
            bus_wr = 1'b0;
            r = int'($urandom_range(0, 99));
            if (r < 12) begin
                bus_rd   = 1'b1;
                bus_addr = 2'($urandom_range(0, 3));
            end else if (r < 17) begin
                bus_wr    = 1'b1;
                bus_addr  = 2'd1;
                bus_wdata = $urandom;
            end else if (r < 19) begin
                w      = $urandom;
                w[7:6] = 2'b00;
                w[0]   = 1'b1;
                bus_wr    = 1'b1;
                bus_addr  = 2'd0;
                bus_wdata = w;
            end else if (r < 22) begin
                bus_rd    = 1'b1;
                bus_wr    = 1'b1;
                bus_addr  = 2'd1;
                bus_wdata = $urandom;
            end
            step();
        end
        bus_rd = 1'b0;
        bus_wr = 1'b0;
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
